// File: rtl/axi4_stream_rr_arb.sv
// Packet-level round-robin arbiter: merges NUM_SRC AXI4-Stream sources onto one
// registered master stream. A winning source keeps the output until its tlast beat
// is accepted; the winning index travels with each beat on m_tid.
module axi4_stream_rr_arb #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEST_W  = 4,
    parameter int unsigned USER_W  = 1,
    localparam int unsigned SID_W  = $clog2(NUM_SRC),
    localparam int unsigned KEEP_W = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          s_tvalid,
    output logic [NUM_SRC-1:0]          s_tready,
    input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]   s_tkeep,
    input  logic [NUM_SRC-1:0]          s_tlast,
    input  logic [NUM_SRC*DEST_W-1:0]   s_tdest,
    input  logic [NUM_SRC*USER_W-1:0]   s_tuser,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic [KEEP_W-1:0]           m_tkeep,
    output logic                        m_tlast,
    output logic [DEST_W-1:0]           m_tdest,
    output logic [USER_W-1:0]           m_tuser,
    output logic [SID_W-1:0]            m_tid,
    output logic                        busy,
    output logic [SID_W-1:0]            grant,
    output logic [15:0]                 pkt_cnt
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e             r_state, w_state_d;
    logic [SID_W-1:0]   r_rr_ptr, w_rr_ptr_d;
    logic [SID_W-1:0]   r_grant, w_grant_d;
    logic [15:0]        r_pkt_cnt, w_pkt_cnt_d;

    logic               r_m_tvalid;
    logic [DATA_W-1:0]  r_m_tdata;
    logic [KEEP_W-1:0]  r_m_tkeep;
    logic               r_m_tlast;
    logic [DEST_W-1:0]  r_m_tdest;
    logic [USER_W-1:0]  r_m_tuser;
    logic [SID_W-1:0]   r_m_tid;

    logic [DATA_W-1:0]  w_data [NUM_SRC];
    logic [KEEP_W-1:0]  w_keep [NUM_SRC];
    logic [DEST_W-1:0]  w_dest [NUM_SRC];
    logic [USER_W-1:0]  w_user [NUM_SRC];

    logic [SID_W-1:0]   w_idx;
    logic [SID_W-1:0]   w_rr_sel;
    logic               w_rr_found;
    logic [SID_W-1:0]   w_sel;
    logic [SID_W-1:0]   w_sel_next;
    logic               w_locked;
    logic               w_any_valid;
    logic               w_out_rdy;
    logic               w_grant_ok;
    logic               w_xfer;
    logic               w_sel_last;
    logic [NUM_SRC-1:0] w_s_tready;

    // Unpack the flat per-source payload buses into indexable arrays.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_data[gi] = s_tdata[gi*DATA_W +: DATA_W];
        assign w_keep[gi] = s_tkeep[gi*KEEP_W +: KEEP_W];
        assign w_dest[gi] = s_tdest[gi*DEST_W +: DEST_W];
        assign w_user[gi] = s_tuser[gi*USER_W +: USER_W];
    end

    // First requesting source at or after rr_ptr, wrapping; no bubble cycle.
    always_comb begin
        w_rr_sel   = r_rr_ptr;
        w_rr_found = 1'b0;
        w_idx      = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_idx = SID_W'((32'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_rr_found && s_tvalid[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = w_idx;
            end
        end
    end

    assign w_locked    = (r_state == StLocked);
    assign w_any_valid = |s_tvalid;
    assign w_sel       = w_locked ? r_grant : w_rr_sel;
    assign w_out_rdy   = !r_m_tvalid || m_tready;
    // Ready is withheld while reset is asserted so no beat is taken into a clearing stage.
    assign w_grant_ok  = !rst && w_out_rdy && (w_locked || w_any_valid);
    assign w_xfer      = s_tvalid[w_sel] && w_grant_ok;
    assign w_sel_last  = s_tlast[w_sel];
    assign w_sel_next  = (w_sel == SID_W'(NUM_SRC - 1)) ? '0 : w_sel + SID_W'(1);

    // Only the selected source ever sees ready.
    always_comb begin
        w_s_tready = '0;
        if (w_grant_ok) begin
            w_s_tready[w_sel] = 1'b1;
        end
    end

    // Next-state logic for the packet lock, round-robin pointer and packet counter.
    always_comb begin
        w_state_d   = r_state;
        w_grant_d   = r_grant;
        w_rr_ptr_d  = r_rr_ptr;
        w_pkt_cnt_d = r_pkt_cnt;
        case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    w_grant_d = w_sel;
                    if (w_sel_last) begin
                        w_rr_ptr_d  = w_sel_next;
                        w_pkt_cnt_d = r_pkt_cnt + 16'd1;
                    end else begin
                        w_state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                // w_sel equals r_grant here, so w_sel_next is grant+1.
                if (w_xfer && w_sel_last) begin
                    w_state_d   = StIdle;
                    w_rr_ptr_d  = w_sel_next;
                    w_pkt_cnt_d = r_pkt_cnt + 16'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_rr_ptr  <= w_rr_ptr_d;
            r_grant   <= w_grant_d;
            r_pkt_cnt <= w_pkt_cnt_d;
        end
    end

    // Forward output stage: load on transfer, drain when downstream takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tdest  <= '0;
            r_m_tuser  <= '0;
            r_m_tid    <= '0;
        end else if (w_xfer) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_data[w_sel];
            r_m_tkeep  <= w_keep[w_sel];
            r_m_tlast  <= w_sel_last;
            r_m_tdest  <= w_dest[w_sel];
            r_m_tuser  <= w_user[w_sel];
            r_m_tid    <= w_sel;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign s_tready = w_s_tready;
    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_tkeep  = r_m_tkeep;
    assign m_tlast  = r_m_tlast;
    assign m_tdest  = r_m_tdest;
    assign m_tuser  = r_m_tuser;
    assign m_tid    = r_m_tid;
    assign busy     = w_locked;
    assign grant    = r_grant;
    assign pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_axi4_stream_rr_arb.sv
// Bench for axi4_stream_rr_arb: queue-driven sources, packet-order model, per-test checks.
module tb_axi4_stream_rr_arb;

    localparam int NSRC   = 4;
    localparam int DATA_W = 32;
    localparam int DEST_W = 4;
    localparam int USER_W = 1;
    localparam int KEEP_W = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  dest;
        logic [0:0]  user;
        logic [1:0]  tid;
    } beat_t;

    logic                     clk;
    logic                     rst;
    logic [NSRC-1:0]          s_tvalid;
    logic [NSRC-1:0]          s_tready;
    logic [NSRC*DATA_W-1:0]   s_tdata;
    logic [NSRC*KEEP_W-1:0]   s_tkeep;
    logic [NSRC-1:0]          s_tlast;
    logic [NSRC*DEST_W-1:0]   s_tdest;
    logic [NSRC*USER_W-1:0]   s_tuser;
    logic                     m_tvalid;
    logic                     m_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic [KEEP_W-1:0]        m_tkeep;
    logic                     m_tlast;
    logic [DEST_W-1:0]        m_tdest;
    logic [USER_W-1:0]        m_tuser;
    logic [1:0]               m_tid;
    logic                     busy;
    logic [1:0]               grant;
    logic [15:0]              pkt_cnt;

    axi4_stream_rr_arb #(
        .NUM_SRC (NSRC),
        .DATA_W  (DATA_W),
        .DEST_W  (DEST_W),
        .USER_W  (USER_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tdest  (s_tdest),
        .s_tuser  (s_tuser),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tdest  (m_tdest),
        .m_tuser  (m_tuser),
        .m_tid    (m_tid),
        .busy     (busy),
        .grant    (grant),
        .pkt_cnt  (pkt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int        n_cmp;
    int        n_fail;
    beat_t     src_q [NSRC][$];
    beat_t     exp_q [$];
    beat_t     obs_q [$];
    int        sent [NSRC];
    logic [NSRC-1:0] pause;
    bit        rand_ready;
    bit        stall_prev;
    beat_t     stall_beat;
    int        stall_viol;
    int        stall_cnt;

    function automatic beat_t mk_beat(input int src, input bit last);
        beat_t b;
        b.data = $urandom;
        b.keep = 4'($urandom);
        b.last = last;
        b.dest = 4'($urandom);
        b.user = 1'($urandom);
        b.tid  = 2'(src);
        return b;
    endfunction

    function automatic beat_t cur_out();
        beat_t b;
        b.data = m_tdata;
        b.keep = m_tkeep;
        b.last = m_tlast;
        b.dest = m_tdest;
        b.user = m_tuser;
        b.tid  = m_tid;
        return b;
    endfunction

    // Present the head of each source queue; a paused or empty source drops tvalid.
    task automatic drive();
        for (int i = 0; i < NSRC; i++) begin
            beat_t b;
            bit    v;
            v = (src_q[i].size() > 0) && !pause[i];
            b = '0;
            if (v) b = src_q[i][0];
            s_tvalid[i]                   = v;
            s_tlast[i]                    = b.last;
            s_tdata[i*DATA_W +: DATA_W]   = b.data;
            s_tkeep[i*KEEP_W +: KEEP_W]   = b.keep;
            s_tdest[i*DEST_W +: DEST_W]   = b.dest;
            s_tuser[i*USER_W +: USER_W]   = b.user;
        end
    endtask

    // One clock: observe handshakes mid-cycle, advance at posedge+1.
    task automatic tick();
        logic [NSRC-1:0] hs;
        bit              ohs;
        beat_t           o;
        #3;
        hs  = s_tvalid & s_tready;
        ohs = m_tvalid && m_tready;
        o   = cur_out();
        if (stall_prev && (!m_tvalid || o !== stall_beat)) stall_viol++;
        if (m_tvalid && !m_tready) stall_cnt++;
        stall_prev = m_tvalid && !m_tready;
        stall_beat = o;
        if (ohs) obs_q.push_back(o);
        @(posedge clk);
        #1;
        for (int i = 0; i < NSRC; i++) begin
            if (hs[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                sent[i]++;
            end
        end
        if (rand_ready) m_tready = 1'($urandom_range(0, 1));
        drive();
    endtask

    // Packet-level round robin: from ptr, the first source with a pending packet
    // sends the whole packet, then ptr moves just past it.
    task automatic plan_rr(input int start_ptr);
        int pos [NSRC];
        int ptr;
        ptr = start_ptr;
        for (int i = 0; i < NSRC; i++) pos[i] = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            int  s;
            bit  done;
            s = -1;
            for (int k = 0; k < NSRC; k++) begin
                int c;
                c = (ptr + k) % NSRC;
                if (s < 0 && pos[c] < src_q[c].size()) s = c;
            end
            if (s < 0) break;
            done = 1'b0;
            while (!done && pos[s] < src_q[s].size()) begin
                exp_q.push_back(src_q[s][pos[s]]);
                done = src_q[s][pos[s]].last;
                pos[s]++;
            end
            ptr = (s + 1) % NSRC;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        m_tready   = 1'b1;
        rand_ready = 1'b0;
        pause      = '0;
        stall_prev = 1'b0;
        stall_viol = 0;
        stall_cnt  = 0;
        for (int i = 0; i < NSRC; i++) begin
            src_q[i].delete();
            sent[i] = 0;
        end
        exp_q.delete();
        obs_q.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #3;
            n_cmp++;
            if (m_tvalid !== 1'b0 || s_tready !== 4'b0 || busy !== 1'b0 || pkt_cnt !== 16'd0
                || grant !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: tvalid=%b tready=%b busy=%b cnt=%0d grant=%0d, want all 0",
                         c, m_tvalid, s_tready, busy, pkt_cnt, grant);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        int ticks;
        bit c12;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NSRC; s++)
                for (int b = 0; b < 3; b++) src_q[s].push_back(mk_beat(s, b == 2));
        plan_rr(0);
        drive();
        ticks = 0;
        c12   = 1'b0;
        while (obs_q.size() < 24 && ticks < 100) begin
            tick();
            ticks++;
            if (obs_q.size() == 12 && !c12) begin
                c12 = 1'b1;
                n_cmp++;
                if (pkt_cnt !== 16'd4) begin
                    n_fail++;
                    $display("FAIL rr_pkt_cnt_12: got %0d want 4", pkt_cnt);
                end
            end
        end
        n_cmp++;
        if (ticks !== 25) begin
            n_fail++;
            $display("FAIL rr_throughput: 24 beats took %0d cycles, want 25", ticks);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rr_beat %0d: got %h want %h (tid want %0d)",
                         i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i], exp_q[i].tid);
            end
        end
        n_cmp++;
        if (pkt_cnt !== 16'd8 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_end: cnt=%0d busy=%b want 8/0", pkt_cnt, busy);
        end
    endtask

    task automatic test_lock_hold();
        int guard;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            beat_t x;
            x = mk_beat(2, b == 3);
            src_q[2].push_back(x);
            exp_q.push_back(x);
        end
        drive();
        guard = 0;
        while (sent[2] < 2 && guard < 20) begin
            tick();
            guard++;
        end
        pause[2] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            beat_t x;
            x = mk_beat(0, b == 1);
            src_q[0].push_back(x);
            exp_q.push_back(x);
        end
        drive();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (s_tvalid[0] !== 1'b1 || s_tready[0] !== 1'b0 || busy !== 1'b1 || grant !== 2'd2) begin
                n_fail++;
                $display("FAIL lock_hold cyc %0d: tready0=%b busy=%b grant=%0d, want 0/1/2",
                         c, s_tready[0], busy, grant);
            end
            tick();
        end
        pause[2] = 1'b0;
        drive();
        guard = 0;
        while (obs_q.size() < 6 && guard < 40) begin
            tick();
            guard++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lock_beat %0d: got %h want %h",
                         i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        n_cmp++;
        if (pkt_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL lock_pkt_cnt: got %0d want 2", pkt_cnt);
        end
    endtask

    task automatic test_random_stall();
        int guard;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            beat_t x;
            x = mk_beat(1, 1'b1);
            x.data = 32'hA0 + 32'(2 * k);
            src_q[1].push_back(x);
            x = mk_beat(3, 1'b1);
            x.data = 32'hA1 + 32'(2 * k);
            src_q[3].push_back(x);
        end
        plan_rr(0);
        rand_ready = 1'b1;
        drive();
        guard = 0;
        while (obs_q.size() < 16 && guard < 400) begin
            tick();
            guard++;
        end
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || exp_q[i].data !== 32'hA0 + 32'(i)) begin
                n_fail++;
                $display("FAIL stall_beat %0d: got %h want %h",
                         i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() !== 16) begin
            n_fail++;
            $display("FAIL stall_count: got %0d beats want 16", obs_q.size());
        end
        n_cmp++;
        if (stall_viol !== 0 || stall_cnt == 0) begin
            n_fail++;
            $display("FAIL stall_stable: %0d changes during %0d stalls, want 0 changes", stall_viol,
                     stall_cnt);
        end
        n_cmp++;
        if (pkt_cnt !== 16'd16) begin
            n_fail++;
            $display("FAIL stall_pkt_cnt: got %0d want 16", pkt_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        int guard;
        do_reset();
        src_q[2].push_back(mk_beat(2, 1'b1));
        drive();
        guard = 0;
        while (sent[2] < 1 && guard < 20) begin
            tick();
            guard++;
        end
        for (int b = 0; b < 4; b++) src_q[1].push_back(mk_beat(1, b == 3));
        drive();
        guard = 0;
        while (sent[1] < 2 && guard < 20) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (busy !== 1'b1 || grant !== 2'd1 || pkt_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midpkt_pre: busy=%b grant=%0d cnt=%0d, want 1/1/1", busy, grant, pkt_cnt);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (s_tready !== 4'b0) begin
            n_fail++;
            $display("FAIL midpkt_rst_ready: got %b want 0000", s_tready);
        end
        tick();
        n_cmp++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || grant !== 2'd0 || pkt_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midpkt_post: tvalid=%b busy=%b grant=%0d cnt=%0d, want all 0",
                     m_tvalid, busy, grant, pkt_cnt);
        end
        rst = 1'b0;
        src_q[1].delete();
        obs_q.delete();
        exp_q.delete();
        for (int b = 0; b < 2; b++) begin
            beat_t x;
            x = mk_beat(3, b == 1);
            src_q[3].push_back(x);
            exp_q.push_back(x);
        end
        drive();
        #1;
        n_cmp++;
        if (s_tready !== 4'b1000) begin
            n_fail++;
            $display("FAIL midpkt_regrant: tready=%b want 1000", s_tready);
        end
        guard = 0;
        while (obs_q.size() < 2 && guard < 20) begin
            tick();
            guard++;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midpkt_beat %0d: got %h want %h",
                         i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
            end
        end
        n_cmp++;
        if (pkt_cnt !== 16'd1 || grant !== 2'd3) begin
            n_fail++;
            $display("FAIL midpkt_end: cnt=%0d grant=%0d, want 1/3", pkt_cnt, grant);
        end
    endtask

    task automatic test_pkt_cnt_wrap();
        int n;
        bit seen;
        do_reset();
        s_tvalid = 4'b0001;
        s_tlast  = 4'b0001;
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 70000 && n < 65536; c++) begin
            #3;
            if (s_tvalid[0] && s_tready[0]) n++;
            @(posedge clk);
            #1;
            if (n == 65535 && !seen) begin
                seen = 1'b1;
                n_cmp++;
                if (pkt_cnt !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL wrap_ffff: got %h want ffff", pkt_cnt);
                end
            end
        end
        s_tvalid = '0;
        s_tlast  = '0;
        n_cmp++;
        if (n !== 65536 || pkt_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: %0d packets, cnt=%h, want 65536 packets and cnt 0000", n,
                     pkt_cnt);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tdest  = '0;
        s_tuser  = '0;
        test_reset();
        test_round_robin();
        test_lock_hold();
        test_random_stall();
        test_reset_mid_packet();
        test_pkt_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
